// File: rtl/led_scheduler.sv
// Round-robin owner of the shared RGB LED: grants one requester at a time for its
// hold time, then drives the active-low pins with a global PWM dimming level.
module led_scheduler #(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 12000,
  parameter int PWM_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    color,
  input  logic [8*N_REQ-1:0]    hold,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic                  LED_R,
  output logic                  LED_G,
  output logic                  LED_B
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(TICK_DIV - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      last;
  logic [DIV_W-1:0]      div_cnt;
  logic [7:0]            hold_cnt;
  logic [2:0]            color_q;
  logic [PWM_BITS-1:0]   pwm_cnt;

  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [2:0]            win_color;
  logic [7:0]            win_hold;
  logic                  tick;
  logic                  release_now;
  logic                  lit;

  // Search starts just past the previous owner so every requester gets a turn.
  always_comb begin
    int cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_color   = color[3*int'(win_idx) +: 3];
  assign win_hold    = hold[8*int'(win_idx) +: 8];
  assign tick        = (div_cnt == DIV_TC);
  // While owning, last always names the current owner.
  assign release_now = !req[last] || (tick && (hold_cnt == 8'd1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      last     <= LAST_INIT;
      div_cnt  <= '0;
      hold_cnt <= '0;
      color_q  <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= OWN;
            grant    <= ONE_HOT0 << win_idx;
            busy     <= 1'b1;
            last     <= win_idx;
            color_q  <= win_color;
            hold_cnt <= (win_hold == 8'd0) ? 8'd1 : win_hold;
            div_cnt  <= '0;
          end
        end
        OWN: begin
          if (release_now) begin
            state   <= GAP;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= ONE_HOT0 << last;
            div_cnt <= '0;
          end else if (tick) begin
            div_cnt  <= '0;
            hold_cnt <= hold_cnt - 8'd1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Duty tops out one step short of 100% because pwm_cnt never exceeds the max brightness.
  assign lit = (state == OWN) && (pwm_cnt < brightness);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt <= '0;
      LED_R   <= 1'b1;
      LED_G   <= 1'b1;
      LED_B   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      LED_R   <= !(lit && color_q[2]);
      LED_G   <= !(lit && color_q[1]);
      LED_B   <= !(lit && color_q[0]);
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: directed scenarios plus random traffic, checked against a
// transaction-level model that predicts owner, release cycle and LED state.
module tb_led_scheduler;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int PB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [N-1:0]  req = '0;
  logic [3*N-1:0] color = '0;
  logic [8*N-1:0] hold = '0;
  logic [PB-1:0] brightness = '0;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic          LED_R;
  logic          LED_G;
  logic          LED_B;

  led_scheduler #(.N_REQ(N), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
    .CLK(CLK), .RST(RST), .req(req), .color(color), .hold(hold),
    .brightness(brightness), .grant(grant), .done(done), .busy(busy),
    .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  // Model: current owner (-1 none), edge at which hold expires, first edge that may arbitrate.
  int          m_owner    = -1;
  int          m_rel      = 0;
  int          m_arb_edge = 1;
  int          m_last     = N - 1;
  logic [2:0]  m_color    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [3*N-1:0] c,
                               input logic [8*N-1:0] h, input logic [PB-1:0] b);
    req        = r;
    color      = c;
    hold       = h;
    brightness = b;
  endtask

  function automatic int pick_winner(input int from_last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(from_last + k) % N]) return (from_last + k) % N;
    end
    return -1;
  endfunction

  // One clock edge: advance the model with the inputs seen at that edge, then compare.
  task automatic step();
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_done;
    logic [2:0]   exp_led;
    logic         on;
    int           w;
    int           hv;
    @(posedge CLK);
    #1;
    n++;
    on      = (m_owner >= 0) && (((n - 1) % (1 << PB)) < int'(brightness));
    exp_led = on ? ~m_color : 3'b111;
    exp_done = '0;
    if (m_owner >= 0) begin
      if (!req[m_owner] || n == m_rel) begin
        exp_done   = N'(1) << m_owner;
        m_owner    = -1;
        m_arb_edge = n + 2;
      end
    end else if (n >= m_arb_edge) begin
      w = pick_winner(m_last, req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_color = color[3*w +: 3];
        hv      = int'(hold[8*w +: 8]);
        if (hv == 0) hv = 1;
        m_rel   = n + hv * TD;
      end
    end
    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    checkOutput("grant", 32'(grant), 32'(exp_grant));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("busy", 32'(busy), 32'(m_owner >= 0));
    checkOutput("leds", 32'({LED_R, LED_G, LED_B}), 32'(exp_led));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic wait_owner(input int target);
    for (int i = 0; i < 60 && m_owner != target; i++) step();
    checkOutput("wait_owner", 32'(m_owner), 32'(target));
  endtask

  // Reset lands between edges; outputs must clear before the next clock.
  task automatic doReset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_leds"}, 32'({LED_R, LED_G, LED_B}), 32'd7);
    @(posedge CLK);
    #3;
    RST        = 1'b0;
    n          = 0;
    m_owner    = -1;
    m_last     = N - 1;
    m_arb_edge = 1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus('0, '0, '0, '0);
    doReset("rst_init");

    // Single red requester, hold 2, full brightness; re-grants while held, then drops.
    applyStimulus(4'b0001, 12'b000_000_000_100, 32'h0000_0002, 4'd15);
    run(12);
    applyStimulus(4'b0000, 12'b000_000_000_100, 32'h0000_0002, 4'd15);
    run(5);

    // Round-robin rotation with all requesters at hold 1.
    applyStimulus(4'b1111, 12'b001_010_100_111, 32'h0101_0101, 4'd9);
    run(30);
    applyStimulus(4'b0000, 12'b001_010_100_111, 32'h0101_0101, 4'd9);
    run(6);

    // Early release of requester 1 three cycles into a long hold.
    applyStimulus(4'b0010, 12'b000_000_110_000, 32'h0000_0A00, 4'd12);
    wait_owner(1);
    run(2);
    applyStimulus(4'b0000, 12'b000_000_110_000, 32'h0000_0A00, 4'd12);
    run(4);

    // Zero hold and zero brightness on requester 2.
    applyStimulus(4'b0100, 12'b000_111_000_000, 32'h0000_0000, 4'd0);
    run(9);
    applyStimulus(4'b0000, 12'b000_111_000_000, 32'h0000_0000, 4'd0);
    run(4);

    // Requester 3 drops on the very edge its hold expires.
    applyStimulus(4'b1000, 12'b101_000_000_000, 32'h0100_0000, 4'd15);
    wait_owner(3);
    for (int i = 0; i < 10 && m_rel != n + 1; i++) step();
    checkOutput("sim_release_align", 32'(m_rel), 32'(n + 1));
    applyStimulus(4'b0000, 12'b101_000_000_000, 32'h0100_0000, 4'd15);
    run(5);

    // Reset while requester 2 owns a lit LED; requester 0 must win afterwards.
    applyStimulus(4'b0100, 12'b000_111_000_000, 32'h0005_0000, 4'd15);
    wait_owner(2);
    run(2);
    doReset("rst_mid_own");
    applyStimulus(4'b1111, 12'b111_111_111_111, 32'h0202_0202, 4'd15);
    step();
    checkOutput("first_after_reset", 32'(grant), 32'd1);
    run(20);

    // Random traffic: requests, colours, short holds and brightness all vary.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(N'($urandom_range(0, 15)), 12'($urandom),
                      {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                       8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
                      PB'($urandom));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
